// File: rtl/rf_write_port_arbiter_if.sv
// Signal bundle between the writeback lanes, ID read ports, pipeline controller
// and the shared register-file write port.
interface rf_write_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb0_valid;
  logic [ADDR_W-1:0] wb0_rd;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid;
  logic [ADDR_W-1:0] wb1_rd;
  logic [DATA_W-1:0] wb1_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [ADDR_W-1:0] rd_a_addr;
  logic              rd_a_hit;
  logic [DATA_W-1:0] rd_a_data;
  logic [ADDR_W-1:0] rd_b_addr;
  logic              rd_b_hit;
  logic [DATA_W-1:0] rd_b_data;

  logic              stall_req;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  rd_a_addr, rd_b_addr,
    output rf_we, rf_waddr, rf_wdata,
    output rd_a_hit, rd_a_data, rd_b_hit, rd_b_data,
    output stall_req, count, overflow
  );

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output rd_a_addr, rd_b_addr,
    input  rf_we, rf_waddr, rf_wdata,
    input  rd_a_hit, rd_a_data, rd_b_hit, rd_b_data,
    input  stall_req, count, overflow
  );
endinterface

// File: rtl/rf_write_port_arbiter.sv
// Dual-lane writeback queue feeding the single RF write port, with youngest-match
// ID bypass from queued writes and a stall request when a pair cannot be absorbed.

// One read-port lookup: scans queue slots oldest to youngest so the youngest match wins.
module rf_wpa_bypass #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] rd_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  localparam int PW = $clog2(DEPTH);

  always_comb begin
    logic [PW-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (vld_i[idx] && (rd_i[idx] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

module rf_write_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input logic                    clk,
  input logic                    reset_n,
  rf_write_port_arbiter_if.slave bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              deq;
  logic              acc0, acc1;
  logic [CNT_W-1:0]  free;
  logic [CNT_W-1:0]  need1;
  logic [PW-1:0]     slot1;
  entry_t            head;

  // Space includes the slot vacated by this edge's retirement.
  always_comb begin
    deq        = (count_q != '0);
    free       = CNT_W'(DEPTH) - count_q + CNT_W'(deq);
    acc0       = bus.wb0_valid && (free >= CNT_W'(1));
    need1      = acc0 ? CNT_W'(2) : CNT_W'(1);
    acc1       = bus.wb1_valid && (free >= need1);
    slot1      = wr_ptr_q + PW'(acc0);
    wr_ptr_d   = wr_ptr_q + PW'(acc0) + PW'(acc1);
    rd_ptr_d   = rd_ptr_q + PW'(deq);
    count_d    = count_q - CNT_W'(deq) + CNT_W'(acc0) + CNT_W'(acc1);
    overflow_d = overflow_q
               | (bus.wb0_valid && !acc0)
               | (bus.wb1_valid && !acc1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload needs no reset: occupancy gates every use of it.
  always_ff @(posedge clk) begin
    if (reset_n && acc0) mem_q[wr_ptr_q] <= '{rd: bus.wb0_rd, data: bus.wb0_data};
    if (reset_n && acc1) mem_q[slot1]    <= '{rd: bus.wb1_rd, data: bus.wb1_data};
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.rf_we    = deq;
  assign bus.rf_waddr = deq ? head.rd   : '0;
  assign bus.rf_wdata = deq ? head.data : '0;

  assign bus.stall_req = (free < CNT_W'(2));
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

  logic [DEPTH-1:0]             slot_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] slot_rd;
  logic [DEPTH-1:0][DATA_W-1:0] slot_data;

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    logic [PW-1:0] age;
    assign age          = PW'(s) - rd_ptr_q;
    assign slot_vld[s]  = (CNT_W'(age) < count_q);
    assign slot_rd[s]   = mem_q[s].rd;
    assign slot_data[s] = mem_q[s].data;
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0]             rd_hit;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_addr       = {bus.rd_b_addr, bus.rd_a_addr};
  assign bus.rd_a_hit  = rd_hit[0];
  assign bus.rd_b_hit  = rd_hit[1];
  assign bus.rd_a_data = rd_data[0];
  assign bus.rd_b_data = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_byp
    rf_wpa_bypass #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_byp (
      .vld_i (slot_vld),
      .rd_i  (slot_rd),
      .data_i(slot_data),
      .head_i(rd_ptr_q),
      .addr_i(rd_addr[p]),
      .hit_o (rd_hit[p]),
      .data_o(rd_data[p])
    );
  end
endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Bench for rf_write_port_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_rf_write_port_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rf_write_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  rf_write_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int rd; int data; } ent_t;
  ent_t mq[$];
  bit   movf = 1'b0;

  typedef struct {
    int rst; int v0; int rd0; int d0; int v1; int rd1; int d1; int ra;
    int e_cnt; int e_we; int e_wa; int e_wd; int e_hit; int e_hd; int e_stall; int e_ovf;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: retire the oldest write, then append each valid lane while room remains.
  task automatic model_edge(input int rst, input int v0, input int rd0, input int d0,
                            input int v1, input int rd1, input int d1);
    ent_t e;
    if (rst != 0) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (v0 != 0) begin
        if (mq.size() < DEPTH) begin e.rd = rd0; e.data = d0; mq.push_back(e); end
        else movf = 1'b1;
      end
      if (v1 != 0) begin
        if (mq.size() < DEPTH) begin e.rd = rd1; e.data = d1; mq.push_back(e); end
        else movf = 1'b1;
      end
    end
  endtask

  function automatic int lookup(input int addr, output int data);
    data = 0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == addr) begin data = mq[i].data; return 1; end
    return 0;
  endfunction

  task automatic check_model(input string tag);
    int ha, hb, da, db, room;
    ha   = lookup(int'(bus.rd_a_addr), da);
    hb   = lookup(int'(bus.rd_b_addr), db);
    room = DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
    chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(mq.size() > 0));
    chk({tag, ".rf_waddr"}, 32'(bus.rf_waddr), (mq.size() > 0) ? 32'(mq[0].rd) : 32'd0);
    chk({tag, ".rf_wdata"}, 32'(bus.rf_wdata), (mq.size() > 0) ? 32'(mq[0].data) : 32'd0);
    chk({tag, ".hit_a"}, 32'(bus.rd_a_hit), 32'(ha));
    chk({tag, ".data_a"}, 32'(bus.rd_a_data), 32'(da));
    chk({tag, ".hit_b"}, 32'(bus.rd_b_hit), 32'(hb));
    chk({tag, ".data_b"}, 32'(bus.rd_b_data), 32'(db));
    chk({tag, ".stall"}, 32'(bus.stall_req), 32'(room < 2));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(movf));
  endtask

  task automatic step(input int rst, input int v0, input int rd0, input int d0,
                      input int v1, input int rd1, input int d1, input int ra, input int rb);
    reset_n       = (rst == 0);
    bus.wb0_valid = (v0 != 0);
    bus.wb0_rd    = ADDR_W'(rd0);
    bus.wb0_data  = DATA_W'(d0);
    bus.wb1_valid = (v1 != 0);
    bus.wb1_rd    = ADDR_W'(rd1);
    bus.wb1_data  = DATA_W'(d1);
    bus.rd_a_addr = ADDR_W'(ra);
    bus.rd_b_addr = ADDR_W'(rb);
    @(posedge clk);
    model_edge(rst, v0, rd0, d0, v1, rd1, d1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // rst v0 rd0 d0 v1 rd1 d1 ra | cnt we wa wd hit hd stall ovf
    tv.push_back('{1,1,1,'h1234,1,2,'h5678,1, 0,0,0,0,0,0,0,0});
    tv.push_back('{0,1,3,'h1111,1,5,'h2222,5, 2,1,3,'h1111,1,'h2222,0,0});
    tv.push_back('{0,0,0,0,0,0,0,3,           1,1,5,'h2222,0,0,0,0});
    tv.push_back('{0,0,0,0,0,0,0,5,           0,0,0,0,0,0,0,0});
    tv.push_back('{0,1,2,'hAAAA,1,2,'hBBBB,2, 2,1,2,'hAAAA,1,'hBBBB,0,0});
    tv.push_back('{0,0,0,0,0,0,0,2,           1,1,2,'hBBBB,1,'hBBBB,0,0});
    tv.push_back('{0,0,0,0,0,0,0,2,           0,0,0,0,0,0,0,0});
    tv.push_back('{0,1,1,'h0101,1,2,'h0202,1, 2,1,1,'h0101,1,'h0101,0,0});
    tv.push_back('{0,1,3,'h0303,1,4,'h0404,4, 3,1,2,'h0202,1,'h0404,0,0});
    tv.push_back('{0,1,5,'h0505,1,6,'h0606,2, 4,1,3,'h0303,0,0,1,0});
    tv.push_back('{0,1,7,'h0707,1,0,'h0808,7, 4,1,4,'h0404,1,'h0707,1,1});
    tv.push_back('{0,0,0,0,0,0,0,0,           3,1,5,'h0505,0,0,0,1});
    tv.push_back('{0,0,0,0,0,0,0,6,           2,1,6,'h0606,1,'h0606,0,1});
    tv.push_back('{0,0,0,0,0,0,0,7,           1,1,7,'h0707,1,'h0707,0,1});
    tv.push_back('{0,0,0,0,0,0,0,7,           0,0,0,0,0,0,0,1});
    tv.push_back('{1,0,0,0,0,0,0,0,           0,0,0,0,0,0,0,0});

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tv[i]) begin
      vec_t v;
      string t;
      v = tv[i];
      t = $sformatf("vec%0d", i);
      step(v.rst, v.v0, v.rd0, v.d0, v.v1, v.rd1, v.d1, v.ra, v.ra);
      chk({t, ".count"},    32'(bus.count),     32'(v.e_cnt));
      chk({t, ".rf_we"},    32'(bus.rf_we),     32'(v.e_we));
      chk({t, ".rf_waddr"}, 32'(bus.rf_waddr),  32'(v.e_wa));
      chk({t, ".rf_wdata"}, 32'(bus.rf_wdata),  32'(v.e_wd));
      chk({t, ".hit_a"},    32'(bus.rd_a_hit),  32'(v.e_hit));
      chk({t, ".data_a"},   32'(bus.rd_a_data), 32'(v.e_hd));
      chk({t, ".hit_b"},    32'(bus.rd_b_hit),  32'(v.e_hit));
      chk({t, ".data_b"},   32'(bus.rd_b_data), 32'(v.e_hd));
      chk({t, ".stall"},    32'(bus.stall_req), 32'(v.e_stall));
      chk({t, ".overflow"}, 32'(bus.overflow),  32'(v.e_ovf));
      check_model(t);
    end

    // Wrap-around: single-lane writes alternating lanes, pointers pass the end twice.
    for (int i = 0; i < 10; i++) begin
      step(0, (i % 2 == 0), i % 8, i, (i % 2 == 1), i % 8, i, i % 8, (i + 7) % 8);
      chk("wrap.count", 32'(bus.count), 32'd1);
      chk("wrap.rf_we", 32'(bus.rf_we), 32'd1);
      chk("wrap.rf_waddr", 32'(bus.rf_waddr), 32'(i % 8));
      chk("wrap.rf_wdata", 32'(bus.rf_wdata), 32'(i));
      chk("wrap.hit_a", 32'(bus.rd_a_data), 32'(i));
      check_model("wrap");
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("wrap.drained", 32'(bus.count), 32'd0);
    chk("wrap.idle_we", 32'(bus.rf_we), 32'd0);

    // Reset while three writes are queued: everything pending is discarded.
    step(0, 1, 1, 'h11, 1, 2, 'h22, 1, 2);
    step(0, 1, 3, 'h33, 1, 4, 'h44, 3, 4);
    chk("mid.count", 32'(bus.count), 32'd3);
    check_model("mid");
    step(1, 0, 0, 0, 0, 0, 0, 3, 4);
    chk("mid.rst_count", 32'(bus.count), 32'd0);
    chk("mid.rst_we", 32'(bus.rf_we), 32'd0);
    chk("mid.rst_hit", 32'(bus.rd_a_hit), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 3, 4);
    chk("mid.after_we", 32'(bus.rf_we), 32'd0);
    chk("mid.after_hit", 32'(bus.rd_b_hit), 32'd0);
    check_model("mid");

    for (int n = 0; n < 3000; n++) begin
      int rst;
      rst = ($urandom_range(0, 99) == 0) ? 1 : 0;
      step(rst,
           ($urandom_range(0, 9) < 6) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
           ($urandom_range(0, 9) < 6) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
           $urandom_range(0, 7), $urandom_range(0, 7));
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
